// File: rtl/vdg_char_gen.sv
// vdg_char_gen
// Character-row generator between the mc6847 VDG character port and an
// external synchronous glyph ROM. The VDG presents {code, row} for each
// character cell scanline; only GLYPH_ROWS of the 2^ROW_W cell rows are
// stored in ROM, starting TOP_PAD rows down. Rows outside that window are
// blanked. Inverse and blink attributes travel alongside the ROM read so
// they meet the returned data in the same cycle. A frame counter driven by
// vsync rising edges provides the blink phase.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   char_a       VDG character address {code, row}
//   inv_in       inverse attribute for char_a
//   blink_in     blink attribute for char_a
//   vsync        active-high vertical sync
//   rom_addr     glyph ROM address {code, glyph row}, combinational
//   rom_dout     glyph ROM data, ROM_LAT cycles after rom_addr
//   char_d_o     registered pixel row to the VDG
//   blink_phase  1 = blinking characters hidden
module vdg_char_gen #(
   parameter int CODE_W     = 7,
   parameter int ROW_W      = 4,
   parameter int GLYPH_ROWS = 8,
   parameter int GROW_W     = 3,
   parameter int TOP_PAD    = 3,
   parameter int ROM_LAT    = 1,
   parameter int DATA_W     = 8,
   parameter int BLINK_W    = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CODE_W+ROW_W-1:0]   char_a,
   input  logic                      inv_in,
   input  logic                      blink_in,
   input  logic                      vsync,
   output logic [CODE_W+GROW_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]         rom_dout,
   output logic [DATA_W-1:0]         char_d_o,
   output logic                      blink_phase
);

   // Window bounds compared one bit wider than the row so that
   // TOP_PAD+GLYPH_ROWS == 2^ROW_W does not wrap to zero.
   localparam logic [ROW_W:0] VIS_LO = (ROW_W+1)'(TOP_PAD);
   localparam logic [ROW_W:0] VIS_HI = (ROW_W+1)'(TOP_PAD + GLYPH_ROWS);

   typedef struct packed {
      logic visible;
      logic inv;
      logic blink;
   } attr_t;

   logic [ROW_W-1:0]   row;
   logic [CODE_W-1:0]  code;
   logic [GROW_W-1:0]  rel;
   logic               visible;
   attr_t              attr_in;
   attr_t              attr_reg [ROM_LAT];
   attr_t              aligned;
   logic               hide;
   logic [DATA_W-1:0]  char_d_reg;
   logic [DATA_W-1:0]  char_d_next;
   logic               vs_q_reg;
   logic [BLINK_W-1:0] blink_cnt_reg;
   logic [BLINK_W-1:0] blink_cnt_next;

   assign row  = char_a[ROW_W-1:0];
   assign code = char_a[CODE_W+ROW_W-1:ROW_W];

   // Only the low GROW_W bits of (row - TOP_PAD) reach the ROM, and the
   // low bits of a wrapped subtraction depend only on the low operand bits.
   assign rel      = row[GROW_W-1:0] - GROW_W'(TOP_PAD);
   assign rom_addr = {code, rel};
   assign visible  = ({1'b0, row} >= VIS_LO) && ({1'b0, row} < VIS_HI);

   assign attr_in = '{visible: visible, inv: inv_in, blink: blink_in};

   // Attribute delay line: stage ROM_LAT-1 lines up with rom_dout.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            attr_reg[i] <= '0;
         end
      end else begin
         attr_reg[0] <= attr_in;
         for (int i = 1; i < ROM_LAT; i++) begin
            attr_reg[i] <= attr_reg[i-1];
         end
      end
   end

   assign aligned = attr_reg[ROM_LAT-1];

   // Blanking (padding row or hidden blink) is applied before inversion,
   // so an inverse padding row comes out all-ones.
   assign hide = ~aligned.visible | (aligned.blink & blink_phase);

   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pix
         assign char_d_next[gi] = aligned.inv ^ (~hide & rom_dout[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         char_d_reg <= '0;
      end else begin
         char_d_reg <= char_d_next;
      end
   end

   assign char_d_o = char_d_reg;

   // Frame counter: one increment per vsync rising edge, however long
   // vsync stays high. Reset has priority, so an edge during reset is lost.
   assign blink_cnt_next = (vsync && !vs_q_reg) ? blink_cnt_reg + 1'b1
                                                : blink_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q_reg      <= 1'b0;
         blink_cnt_reg <= '0;
      end else begin
         vs_q_reg      <= vsync;
         blink_cnt_reg <= blink_cnt_next;
      end
   end

   assign blink_phase = blink_cnt_reg[BLINK_W-1];

endmodule
